// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit: FSM states, ISA opcodes,
// ALU operation codes and datapath mux selects.
package rv32_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXER   = 4'd6,
        S_EXEI   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_JALR   = 4'd11,
        S_LUI    = 4'd12,
        S_AUIPC  = 4'd13,
        S_TRAP   = 4'd14
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        ALUOP_ADD,
        ALUOP_RTYPE,
        ALUOP_ITYPE,
        ALUOP_BRANCH,
        ALUOP_PASSB
    } alu_mode_e;

    localparam logic [1:0] SRCA_PC     = 2'd0;
    localparam logic [1:0] SRCA_OLDPC  = 2'd1;
    localparam logic [1:0] SRCA_RS1    = 2'd2;

    localparam logic [1:0] SRCB_RS2    = 2'd0;
    localparam logic [1:0] SRCB_IMM    = 2'd1;
    localparam logic [1:0] SRCB_FOUR   = 2'd2;

    localparam logic [1:0] RES_ALUOUT  = 2'd0;
    localparam logic [1:0] RES_MEMDATA = 2'd1;
    localparam logic [1:0] RES_ALURES  = 2'd2;

endpackage

// File: rtl/rv32_mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and memory handshake in,
// mux selects, enables and status out.
interface rv32_mc_ctrl_if #(
    parameter int INSTRET_W = 32
);
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic                 alu_zero;
    logic                 mem_ready;
    logic                 mem_req;
    logic                 mem_write;
    logic                 adr_src;
    logic                 ir_write;
    logic                 pc_write;
    logic                 reg_write;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [3:0]           alu_control;
    logic [1:0]           result_src;
    logic                 illegal;
    logic [INSTRET_W-1:0] instret;
    logic [3:0]           state_dbg;

    modport master (
        input  opcode, funct3, funct7b5, alu_zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_control, result_src, illegal, instret, state_dbg
    );

    modport slave (
        output opcode, funct3, funct7b5, alu_zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_control, result_src, illegal, instret, state_dbg
    );
endinterface

// File: rtl/rv32_alu_dec.sv
// Combinational ALU operation decode from funct3/funct7b5, shared by the register,
// immediate and branch execute states.
module rv32_alu_dec
    import rv32_ctrl_pkg::*;
(
    input  alu_mode_e  mode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [3:0] alu_control_o
);

    // funct7b5 selects SUB only for register ops; for immediates it only picks SRA.
    always_comb begin
        alu_control_o = ALU_ADD;
        case (mode_i)
            ALUOP_PASSB: alu_control_o = ALU_PASSB;
            ALUOP_BRANCH: begin
                case (funct3_i[2:1])
                    2'b10:   alu_control_o = ALU_SLT;
                    2'b11:   alu_control_o = ALU_SLTU;
                    default: alu_control_o = ALU_SUB;
                endcase
            end
            ALUOP_RTYPE, ALUOP_ITYPE: begin
                case (funct3_i)
                    3'b000:  alu_control_o = (mode_i == ALUOP_RTYPE && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control_o = ALU_SLL;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b011:  alu_control_o = ALU_SLTU;
                    3'b100:  alu_control_o = ALU_XOR;
                    3'b101:  alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control_o = ALU_OR;
                    default: alu_control_o = ALU_AND;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv32_mc_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared datapath, counts retired instructions and traps on illegal opcodes.
module rv32_mc_ctrl
    import rv32_ctrl_pkg::*;
#(
    parameter int INSTRET_W      = 32,
    parameter bit RESET_PC_WRITE = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    rv32_mc_ctrl_if.master bus
);

    state_e               state_q, state_d;
    logic                 illegal_q;
    logic [INSTRET_W-1:0] instret_q;
    logic                 first_q;

    logic       memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite, retire, taken;
    logic [1:0] aluSrcA, aluSrcB, resultSrc;
    logic [3:0] aluCtl;
    alu_mode_e  aluMode;

    rv32_alu_dec u_alu_dec (
        .mode_i       (aluMode),
        .funct3_i     (bus.funct3),
        .funct7b5_i   (bus.funct7b5),
        .alu_control_o(aluCtl)
    );

    // Branch outcome: beq/bge/bgeu take on a zero ALU result, the others on non-zero.
    assign taken = bus.alu_zero ^ (bus.funct3[0] ^ bus.funct3[2]);

    always_comb begin
        state_d   = state_q;
        memReq    = 1'b0;
        memWrite  = 1'b0;
        adrSrc    = 1'b0;
        irWrite   = 1'b0;
        pcWrite   = 1'b0;
        regWrite  = 1'b0;
        retire    = 1'b0;
        aluSrcA   = SRCA_PC;
        aluSrcB   = SRCB_RS2;
        resultSrc = RES_ALUOUT;
        aluMode   = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                memReq    = 1'b1;
                aluSrcB   = SRCB_FOUR;
                resultSrc = RES_ALURES;
                irWrite   = bus.mem_ready;
                pcWrite   = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXER;
                    OP_ITYPE:          state_d = S_EXEI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
                state_d = (bus.opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                memReq = 1'b1;
                adrSrc = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultSrc = RES_MEMDATA;
                regWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                memReq   = 1'b1;
                memWrite = 1'b1;
                adrSrc   = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXER: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_RS2;
                aluMode = ALUOP_RTYPE;
                state_d = S_ALUWB;
            end
            S_EXEI: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
                aluMode = ALUOP_ITYPE;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_RS2;
                aluMode = ALUOP_BRANCH;
                if (bus.funct3[2:1] == 2'b01) begin
                    state_d = S_TRAP;
                end else begin
                    pcWrite = taken;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            // PC takes the target already in ALUOut while the ALU forms oldPC+4 for the link.
            S_JAL: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_FOUR;
                pcWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
                state_d = S_JAL;
            end
            S_LUI: begin
                aluSrcB = SRCB_IMM;
                aluMode = ALUOP_PASSB;
                state_d = S_ALUWB;
            end
            S_AUIPC: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
                state_d = S_ALUWB;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        if (RESET_PC_WRITE && first_q) pcWrite = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
            first_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            first_q <= 1'b0;
            if (state_q == S_TRAP) illegal_q <= 1'b1;
            if (retire) instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    // Reset forces every output low combinationally so a store in flight is cut the same cycle.
    assign bus.mem_req     = rst & memReq;
    assign bus.mem_write   = rst & memWrite;
    assign bus.adr_src     = rst & adrSrc;
    assign bus.ir_write    = rst & irWrite;
    assign bus.pc_write    = rst & pcWrite;
    assign bus.reg_write   = rst & regWrite;
    assign bus.alu_src_a   = {2{rst}} & aluSrcA;
    assign bus.alu_src_b   = {2{rst}} & aluSrcB;
    assign bus.alu_control = {4{rst}} & aluCtl;
    assign bus.result_src  = {2{rst}} & resultSrc;
    assign bus.illegal     = illegal_q;
    assign bus.instret     = instret_q;
    assign bus.state_dbg   = state_q;

endmodule
